// File: rtl/iob_rr_reg_arb_pkg.sv
// Shared types for the round-robin register arbiter.
// Holds the output-register occupancy encoding.
package iob_rr_reg_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/iob_rr_prio.sv
// Rotating-priority encoder: first set request at or after i_ptr,
// found by scanning a doubled request vector whose low copy is masked.
module iob_rr_prio #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_id,
    output logic             o_any
);

    logic [N_REQ-1:0]   w_mask;
    logic [2*N_REQ-1:0] w_dbl;
    logic               w_found;
    logic [ID_W-1:0]    w_idx;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_mask[i] = (i >= int'(i_ptr));
        end
    end

    // Upper copy is unmasked so the search wraps past N_REQ-1.
    assign w_dbl = {i_req, i_req & w_mask};

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < 2*N_REQ; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found = 1'b1;
                w_idx   = ID_W'(i % N_REQ);
            end
        end
    end

    always_comb begin
        o_grant = '0;
        if (w_found) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    assign o_grant_id = w_idx;
    assign o_any      = w_found;

endmodule

// File: rtl/iob_rr_reg_arb.sv
// Round-robin arbiter feeding one shared output register
// with a valid/ready handshake and back-to-back refill.
module iob_rr_reg_arb
    import iob_rr_reg_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    cke_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [ID_W-1:0]         out_id_o,
    input  logic                    out_ready_i
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [ID_W-1:0]     r_id;

    logic [N_REQ-1:0]    w_grant;
    logic [ID_W-1:0]     w_grant_id;
    logic                w_any;
    logic                w_pop;
    logic                w_can_load;
    logic                w_grant_en;
    logic [DATA_W-1:0]   w_mux;

    iob_rr_prio #(
        .N_REQ (N_REQ)
    ) u_prio (
        .i_req      (req_valid_i),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    assign w_pop      = cke_i && (r_state == ST_FULL) && out_ready_i;
    assign w_can_load = cke_i && ((r_state == ST_EMPTY) || w_pop);
    // Ready must stay low while reset is held, even though state reads EMPTY.
    assign w_grant_en = w_can_load && w_any && !arst_i;

    assign req_ready_o = w_grant_en ? w_grant : '0;

    always_comb begin
        w_mux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_mux = w_mux
                  | (req_data_i[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
        end
    end

    assign w_ptr_nxt = (w_grant_id == ID_W'(N_REQ - 1))
                     ? '0
                     : w_grant_id + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant_en) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_pop && !w_grant_en) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= ST_EMPTY;
        end else if (cke_i) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_ptr  <= '0;
            r_data <= '0;
            r_id   <= '0;
        end else if (w_grant_en) begin
            r_ptr  <= w_ptr_nxt;
            r_data <= w_mux;
            r_id   <= w_grant_id;
        end
    end

    assign out_valid_o = (r_state == ST_FULL);
    assign out_data_o  = r_data;
    assign out_id_o    = r_id;

endmodule

// File: doc/iob_rr_reg_arb.md
# iob_rr_reg_arb

Round-robin arbiter that shares one output register between `N_REQ` requesters. Each cycle it selects one valid requester and loads that requester's data and index into the register. The register then presents the data downstream with a valid/ready handshake. The block sits in front of any single-port sink that several masters must write, such as a shared CSR or a single-entry mailbox. It provides fair access with a throughput of one transfer per cycle.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, must be ≥ 2.
- `DATA_W`, 32: data width per requester.
- `ID_W` (localparam), `$clog2(N_REQ)`: width of the requester index.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `arst_i`  in  1  reset, asynchronous, active-high.
- `cke_i`  in  1  clock enable; when low, all state is frozen.
- `req_valid_i`  in  N_REQ  request valid, one bit per requester.
- `req_data_i`  in  N_REQ*DATA_W  request data; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready_o`  out  N_REQ  one-hot or zero; bit i high means requester i is accepted this cycle.
- `out_valid_o`  out  1  output register holds data.
- `out_data_o`  out  DATA_W  registered data.
- `out_id_o`  out  ID_W  index of the requester whose data is held.
- `out_ready_i`  in  1  downstream consumes the data when high together with `out_valid_o`.

## Operation
- State is one bit: EMPTY (`out_valid_o`=0) or FULL (`out_valid_o`=1).
- Signal definitions, all evaluated only when `cke_i`=1:
  - `pop` = `out_valid_o` & `out_ready_i`.
  - `can_load` = EMPTY | `pop`.
- Priority pointer `ptr` (ID_W bits):
  - Search order is `ptr`, `ptr`+1, …, N_REQ-1, 0, …, `ptr`-1.
  - The winner is the first index with `req_valid_i` high.
- Grant:
  - When `can_load` and any `req_valid_i` bit is set, `req_ready_o` is the one-hot winner.
  - Otherwise `req_ready_o` is 0.
  - `req_ready_o` is combinational from `req_valid_i`, `ptr`, state, `out_ready_i` and `cke_i`.
- Load (on a grant):
  - `out_data_o` ← the winner's data.
  - `out_id_o` ← the winner's index.
  - `out_valid_o` ← 1.
  - `ptr` ← winner+1, wrapping from N_REQ-1 to 0.
- Pop without a grant: `out_valid_o` ← 0; `out_data_o` and `out_id_o` keep their values.
- FULL without `pop`: hold everything and grant nobody. Requesters keep `req_valid_i` asserted and their data stable until their ready bit is seen.
- Pop and grant in the same cycle (FULL and `pop` and any valid): the new data loads and `out_valid_o` stays 1. This gives back-to-back transfers with no bubble.
- `ptr` changes only on a grant. With no requests it stays put.
- `cke_i`=0:
  - No register changes.
  - `req_ready_o`=0.
  - `out_ready_i` is ignored, so no pop occurs.
- Reset values:
  - `out_valid_o`=0, `out_data_o`=0, `out_id_o`=0.
  - `ptr`=0.
  - `req_ready_o`=0 while `arst_i`=1.
- Reset mid-operation: data held in the register is discarded, with no flush and no handshake.

## Timing
- Accept-to-output latency is 1 cycle: a grant on edge k gives `out_valid_o`=1 after edge k.
- Throughput is 1 transfer per cycle while `out_ready_i`=1.
- Fairness: a continuously requesting requester is granted within N_REQ grants.
- Outputs `out_*` are registered. `req_ready_o` has a combinational path from `out_ready_i` and `req_valid_i`; the integration must account for it.
- `arst_i` assertion clears outputs immediately. Deassertion takes effect for the first rising edge after it.

## Structure
- No shared package is needed. `ID_W` is a localparam computed in the module.
- Natural sub-module: `iob_rr_prio`, parameter `N_REQ`.
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot `grant`, `grant_id`, `any`.
  - Purely combinational; implemented as a doubled-vector masked priority encoder.
- Top level holds `ptr`, the output register, the state bit and the data mux. The mux is an AND-OR of the one-hot `grant` with `req_data_i`.

## Test plan
- Reset, N_REQ=4:
  - Stimulus: `arst_i` pulse, all `req_valid_i`=1.
  - Required: outputs 0 during reset. First grant after release is id 0 with `out_data_o`=`req_data_i`[0], then ids 1, 2, 3, 0 on consecutive cycles with `out_ready_i`=1.
- Backpressure:
  - Stimulus: id 2 loaded with 0xA5, then `out_ready_i`=0 for 5 cycles.
  - Required: `out_data_o`=0xA5 and `out_id_o`=2 held, `req_ready_o`=0 throughout. Raising `out_ready_i` gives a pop and a new grant in the same cycle.
- Sparse requests:
  - Stimulus: only requester 3 valid, `ptr`=1.
  - Required: grant 3, then `ptr`=0 (wrap).
  - Stimulus: then only requester 0 valid.
  - Required: grant 0.
- Drain:
  - Stimulus: FULL with id 1, `out_ready_i`=1, no requests.
  - Required: `out_valid_o`→0, `out_data_o` unchanged, `ptr` unchanged.
- Clock enable:
  - Stimulus: `cke_i`=0 for 3 cycles with requests and `out_ready_i`=1.
  - Required: no state change, `req_ready_o`=0. Operation resumes exactly on `cke_i`=1.
- Reset mid-stream:
  - Stimulus: assert `arst_i` while FULL and between clock edges.
  - Required: `out_valid_o` drops immediately. After release, the grant sequence restarts from id 0.
